// File: rtl/divrem_iter_unit_pkg.sv
// Shared parameters for the iterative divide/remainder unit: widths, funct3
// codes, FSM state encoding, latched-operand payload and special-case helpers.
package divrem_iter_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITERS = 32;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned ST_W  = 3;

  localparam logic [F3_W-1:0] F3_DIV  = 3'b100;
  localparam logic [F3_W-1:0] F3_DIVU = 3'b101;
  localparam logic [F3_W-1:0] F3_REM  = 3'b110;
  localparam logic [F3_W-1:0] F3_REMU = 3'b111;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_PREP = 3'd1;
  localparam logic [ST_W-1:0] ST_ITER = 3'd2;
  localparam logic [ST_W-1:0] ST_FIX  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE = 3'd4;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  // Operands captured at acceptance; everything downstream uses these copies.
  typedef struct packed {
    logic [F3_W-1:0] funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } divrem_op_t;

  function automatic logic opIsSigned(input logic [F3_W-1:0] f3);
    return (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic opIsRem(input logic [F3_W-1:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  // Divide-by-zero or signed INT_MIN / -1.
  function automatic logic isSpecialCase(input logic [F3_W-1:0] f3,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
    return (b == '0) || (opIsSigned(f3) && (a == INT_MIN) && (b == ALL_ONES));
  endfunction

  // Architectural result for the special cases above.
  function automatic logic [XLEN-1:0] specialResult(input logic [F3_W-1:0] f3,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
    if (b == '0) begin
      return opIsRem(f3) ? a : ALL_ONES;
    end
    return opIsRem(f3) ? '0 : INT_MIN;
  endfunction

endpackage

// File: rtl/divrem_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and record the quotient bit.
module divrem_step
  import divrem_iter_unit_pkg::*;
(
  input  logic [XLEN-1:0] remIn,
  input  logic [XLEN-1:0] quoIn,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] remOut,
  output logic [XLEN-1:0] quoOut
);

  logic [XLEN:0] trial;
  logic          take;

  // Partial remainder can reach 33 bits after the shift, so compare at XLEN+1.
  always_comb begin
    trial  = {remIn, quoIn[XLEN-1]};
    take   = trial >= {1'b0, divisor};
    remOut = take ? XLEN'(trial - {1'b0, divisor}) : trial[XLEN-1:0];
    quoOut = {quoIn[XLEN-2:0], take};
  end

endmodule

// File: rtl/divrem_iter_unit.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the EX stage. Stalls the pipeline via
// oBusy and pulses oReady with the result.
// Optional feature: define DIVREM_EARLY_OUT_EN to finish divide-by-zero and
// signed overflow in one cycle instead of the full 35-cycle latency.
module divrem_iter_unit
  import divrem_iter_unit_pkg::*;
(
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iStart,
  input  logic            iFlush,
  input  logic [F3_W-1:0] iFunct3,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  output logic            oBusy,
  output logic            oReady,
  output logic [XLEN-1:0] oResult
);

  logic [ST_W-1:0]  state, stateNext;
  divrem_op_t       op, opNext;
  logic [XLEN-1:0]  rem, remNext;
  logic [XLEN-1:0]  quo, quoNext;
  logic [XLEN-1:0]  dvsr, dvsrNext;
  logic [XLEN-1:0]  result, resultNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             negQ, negQNext;
  logic             negR, negRNext;
  logic             ready, readyNext;

  logic             opSigned;
  logic             opRem;
  logic [XLEN-1:0]  absA;
  logic [XLEN-1:0]  absB;
  logic [XLEN-1:0]  stepRem;
  logic [XLEN-1:0]  stepQuo;

  divrem_step uStep (
    .remIn   (rem),
    .quoIn   (quo),
    .divisor (dvsr),
    .remOut  (stepRem),
    .quoOut  (stepQuo)
  );

  // Magnitudes of the latched operands for the unsigned iteration core.
  always_comb begin
    opSigned = opIsSigned(op.funct3);
    opRem    = opIsRem(op.funct3);
    absA     = (opSigned && op.a[XLEN-1]) ? -op.a : op.a;
    absB     = (opSigned && op.b[XLEN-1]) ? -op.b : op.b;
  end

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and datapath-next logic; flush overrides every state.
  always_comb begin
    stateNext  = state;
    opNext     = op;
    remNext    = rem;
    quoNext    = quo;
    dvsrNext   = dvsr;
    resultNext = result;
    cntNext    = cnt;
    negQNext   = negQ;
    negRNext   = negR;
    readyNext  = 1'b0;

    if (iFlush) begin
      stateNext = ST_IDLE;
      cntNext   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            opNext = '{funct3: iFunct3, a: iA, b: iB};
`ifdef DIVREM_EARLY_OUT_EN
            if (isSpecialCase(iFunct3, iA, iB)) begin
              stateNext  = ST_DONE;
              resultNext = specialResult(iFunct3, iA, iB);
              readyNext  = 1'b1;
            end else begin
              stateNext = ST_PREP;
            end
`else
            stateNext = ST_PREP;
`endif
          end
        end

        ST_PREP: begin
          quoNext   = absA;
          dvsrNext  = absB;
          remNext   = '0;
          negQNext  = opSigned && (op.a[XLEN-1] ^ op.b[XLEN-1]);
          negRNext  = opSigned && op.a[XLEN-1];
          cntNext   = '0;
          stateNext = ST_ITER;
        end

        ST_ITER: begin
          remNext = stepRem;
          quoNext = stepQuo;
          if (cnt == CNT_W'(ITERS - 1)) begin
            cntNext   = '0;
            stateNext = ST_FIX;
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end

        ST_FIX: begin
          if (isSpecialCase(op.funct3, op.a, op.b)) begin
            resultNext = specialResult(op.funct3, op.a, op.b);
          end else if (opRem) begin
            resultNext = negR ? -rem : rem;
          end else begin
            resultNext = negQ ? -quo : quo;
          end
          readyNext = 1'b1;
          stateNext = ST_DONE;
        end

        ST_DONE: begin
          stateNext = ST_IDLE;
        end

        default: begin
          stateNext = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      op     <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      result <= '0;
      cnt    <= '0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      ready  <= 1'b0;
    end else begin
      op     <= opNext;
      rem    <= remNext;
      quo    <= quoNext;
      dvsr   <= dvsrNext;
      result <= resultNext;
      cnt    <= cntNext;
      negQ   <= negQNext;
      negR   <= negRNext;
      ready  <= readyNext;
    end
  end

  // Busy also covers the acceptance cycle so the hazard unit stalls immediately.
  assign oBusy = !iRST && ((state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX) ||
                           ((state == ST_IDLE) && iStart && !iFlush));
  assign oReady  = ready;
  assign oResult = result;

endmodule

// File: tb/tb_divrem_iter_unit.sv
// Scoreboard bench for divrem_iter_unit: stimulus pushes expected results and
// latencies, a negedge monitor pops and compares on every oReady pulse.
module tb_divrem_iter_unit;

`ifdef DIVREM_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 35;
`endif
  localparam int LAT = 35;

  logic        iCLK;
  logic        iRST;
  logic        iStart;
  logic        iFlush;
  logic [2:0]  iFunct3;
  logic [31:0] iA;
  logic [31:0] iB;
  logic        oBusy;
  logic        oReady;
  logic [31:0] oResult;

  typedef struct {
    string       nm;
    logic [31:0] res;
    int          startCyc;
    int          lat;
  } exp_t;

  exp_t        sbQ[$];
  exp_t        monE;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] lastRes;

  divrem_iter_unit dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iStart  (iStart),
    .iFlush  (iFlush),
    .iFunct3 (iFunct3),
    .iA      (iA),
    .iB      (iB),
    .oBusy   (oBusy),
    .oReady  (oReady),
    .oResult (oResult)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every oReady pulse must match the oldest pending expectation.
  always @(negedge iCLK) begin
    if (!iRST && oReady) begin
      if (sbQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: oReady=1 at cycle %0d with nothing pending, required 0", cyc);
      end else begin
        monE = sbQ.pop_front();
        checkVal({monE.nm, "_result"}, oResult, monE.res);
        checkVal({monE.nm, "_latency"}, 32'(cyc - monE.startCyc), 32'(monE.lat));
      end
    end
  end

  task automatic pushExp(input string nm, input logic [31:0] res, input int startCyc, input int lat);
    exp_t e;
    e.nm = nm;
    e.res = res;
    e.startCyc = startCyc;
    e.lat = lat;
    sbQ.push_back(e);
  endtask

  task automatic waitDrain(input string nm);
    int n = 0;
    while (sbQ.size() > 0 && n < 100) begin
      @(posedge iCLK);
      n++;
    end
    tests++;
    if (sbQ.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d results still pending, required 0", nm, sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic runOp(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(negedge iCLK);
    iStart = 1'b1;
    iFunct3 = f3;
    iA = a;
    iB = b;
    pushExp(nm, exp, cyc, lat);
    #1 checkVal({nm, "_busy0"}, 32'(oBusy), 32'd1);
    @(negedge iCLK);
    iStart = 1'b0;
    waitDrain(nm);
    repeat (3) @(negedge iCLK);
    checkVal({nm, "_hold"}, oResult, exp);
    checkVal({nm, "_idle"}, 32'(oBusy), 32'd0);
    lastRes = exp;
  endtask

  initial begin
    int k;
    iRST = 1'b1;
    iStart = 1'b0;
    iFlush = 1'b0;
    iFunct3 = 3'b000;
    iA = '0;
    iB = '0;
    lastRes = '0;
    repeat (2) @(negedge iCLK);
    checkVal("reset_busy", 32'(oBusy), 32'd0);
    checkVal("reset_ready", 32'(oReady), 32'd0);
    checkVal("reset_result", oResult, 32'h0);
    iRST = 1'b0;

    // Main function, signed and unsigned.
    runOp("div_m20_3",  3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, LAT);
    runOp("rem_m20_3",  3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, LAT);
    runOp("divu_big",   3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, LAT);
    runOp("remu_big",   3'b111, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, LAT);
    runOp("div_100_m7", 3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT);
    runOp("rem_100_m7", 3'b110, 32'd100, 32'hFFFF_FFF9, 32'd2, LAT);
    runOp("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, LAT);

    // Special cases.
    runOp("div_7_0",    3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    runOp("rem_7_0",    3'b110, 32'd7, 32'd0, 32'd7, SPEC_LAT);
    runOp("div_m7_0",   3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    runOp("rem_m7_0",   3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, SPEC_LAT);
    runOp("divu_7_0",   3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    runOp("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    runOp("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPEC_LAT);

    // Flush in cycle 10: no ready pulse, result unchanged.
    @(negedge iCLK);
    iStart = 1'b1;
    iFunct3 = 3'b100;
    iA = 32'd100;
    iB = 32'd7;
    k = cyc;
    @(negedge iCLK);
    iStart = 1'b0;
    while (cyc < k + 10) @(negedge iCLK);
    iFlush = 1'b1;
    @(negedge iCLK);
    iFlush = 1'b0;
    checkVal("flush_busy", 32'(oBusy), 32'd0);
    checkVal("flush_ready", 32'(oReady), 32'd0);
    repeat (40) @(negedge iCLK);
    checkVal("flush_result", oResult, lastRes);

    // Flush wins over a simultaneous start.
    @(negedge iCLK);
    iStart = 1'b1;
    iFlush = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    iFlush = 1'b0;
    checkVal("flushstart_busy", 32'(oBusy), 32'd0);
    repeat (40) @(negedge iCLK);
    checkVal("flushstart_result", oResult, lastRes);

    // Reset in cycle 20: outputs clear asynchronously, then a fresh op works.
    @(negedge iCLK);
    iStart = 1'b1;
    iFunct3 = 3'b101;
    iA = 32'd55;
    iB = 32'd5;
    k = cyc;
    @(negedge iCLK);
    iStart = 1'b0;
    while (cyc < k + 20) @(negedge iCLK);
    iRST = 1'b1;
    #1;
    checkVal("rst_mid_busy", 32'(oBusy), 32'd0);
    checkVal("rst_mid_ready", 32'(oReady), 32'd0);
    checkVal("rst_mid_result", oResult, 32'h0);
    @(negedge iCLK);
    iRST = 1'b0;
    runOp("divu_after_rst", 3'b101, 32'd1000, 32'd10, 32'd100, LAT);

    // Back-to-back with iStart held high; operand changes mid-op are ignored.
    @(negedge iCLK);
    iStart = 1'b1;
    iFunct3 = 3'b100;
    iA = 32'hFFFF_FFEC;
    iB = 32'd3;
    k = cyc;
    pushExp("b2b_first", 32'hFFFF_FFFA, k, LAT);
    pushExp("b2b_second", 32'hFFFF_FFF2, k + 36, LAT);
    repeat (2) @(negedge iCLK);
    iA = 32'd100;
    iB = 32'hFFFF_FFF9;
    while (cyc < k + 37) @(negedge iCLK);
    iStart = 1'b0;
    waitDrain("b2b");
    repeat (3) @(negedge iCLK);
    checkVal("b2b_hold", oResult, 32'hFFFF_FFF2);

    repeat (5) @(negedge iCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divrem_iter_unit.md
DIVREM_ITER_UNIT -- requirements
Module: divrem_iter_unit

Interface
REQ-001 SHALL have port iCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port iRST, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port iStart, input, 1 bit: an EX-stage DIV/DIVU/REM/REMU instruction requests an operation.
REQ-004 SHALL have port iFlush, input, 1 bit: abort any operation in progress (exception or IDEX flush).
REQ-005 SHALL have port iFunct3, input, 3 bits: operation select; 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports iA and iB, input, 32 bits each: dividend and divisor (forwarded operands).
REQ-007 SHALL have port oBusy, output, 1 bit: an operation is in flight; the hazard unit stalls the whole pipeline while it is high.
REQ-008 SHALL have port oReady, output, 1 bit: a one-cycle pulse marking oResult valid; the hazard unit releases its stall on this pulse.
REQ-009 SHALL have port oResult, output, 32 bits: quotient or remainder.

Function
REQ-010 SHALL implement FSM states IDLE, PREP, ITER, FIX and DONE.
REQ-011 SHALL, in IDLE with iStart=1 and iFlush=0, latch iA, iB and iFunct3 and go to PREP; this cycle is acceptance cycle 0.
REQ-012 SHALL, in PREP (cycle 1), take absolute values of signed operands and record the quotient and remainder signs.
REQ-013 SHALL, in ITER, run 32 radix-2 restoring iterations, one per cycle (cycles 2-33), with a 6-bit iteration counter that wraps 31->0 as it exits to FIX.
REQ-014 SHALL, in FIX (cycle 34), apply sign correction: quotient negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-015 SHALL, in DONE (cycle 35), drive oReady=1 for exactly one cycle and then return to IDLE.
REQ-016 SHALL drive oBusy=1 in PREP, ITER and FIX, and also in cycle 0 whenever iStart=1, so that no stall bubble is lost.
REQ-017 SHALL hold oResult stable from DONE until the next acceptance.
REQ-018 SHALL ignore iStart and operand changes outside IDLE; operands are the latched copies.
REQ-019 SHALL, when iStart is high in the cycle after DONE, accept it as a new operation; back-to-back divides are therefore supported.
REQ-020 SHALL, on divide-by-zero, return quotient 0xFFFFFFFF and remainder equal to the dividend, for both signed and unsigned operations.
REQ-021 SHALL, on signed overflow (0x80000000 / 0xFFFFFFFF), return quotient 0x80000000 and remainder 0.
REQ-022 SHALL, on iFlush=1 in any state, go to IDLE the next cycle with oBusy=0 and oReady=0, leaving oResult unchanged; iFlush takes priority over a simultaneous iStart.

Reset
REQ-023 SHALL, on iRST=1, go immediately to IDLE with oBusy=0, oReady=0, oResult=0 and the iteration counter at 0, including mid-operation; the operation is discarded.

Configuration
REQ-024 SHALL honour macro DIVREM_EARLY_OUT_EN: when defined, divide-by-zero and signed overflow are detected in cycle 0, and the FSM goes IDLE->DONE with oReady in cycle 1.
REQ-025 SHALL, when DIVREM_EARLY_OUT_EN is undefined, give every operation the full 35-cycle latency, with the special-case results still per REQ-020/021.

Structure
REQ-026 SHALL take its FSM state encoding, funct3 codes, XLEN=32 and iteration count 32 from the shared parameters package.
REQ-027 SHALL instantiate one combinational sub-module divrem_step (one restoring shift/subtract/compare step); the FSM and sign logic stay in the top module.

Verification
REQ-028 SHALL cover: DIV iA=-20 (0xFFFFFFEC), iB=3 -> oReady in cycle 35, oResult 0xFFFFFFFA (-6); REM on the same operands -> 0xFFFFFFFE (-2).
REQ-029 SHALL cover: DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF; REMU on the same operands -> 0xF.
REQ-030 SHALL cover: DIV 7/0 -> 0xFFFFFFFF and REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; all with oReady in cycle 1 with the macro defined and in cycle 35 without it.
REQ-031 SHALL cover: iFlush asserted in cycle 10 of an operation -> IDLE next cycle, no oReady pulse, oResult unchanged.
REQ-032 SHALL cover: iRST pulsed in cycle 20 -> oBusy, oReady and oResult are 0 asynchronously, then a new iStart completes correctly.
REQ-033 SHALL cover: two back-to-back DIVs with iStart held high -> two oReady pulses, 36 cycles apart, each with the correct result.
